// File: rtl/cr_prefix_attach_mem_arb_pkg.sv
// Shared types and defaults for the prefix-attach memory arbiter.
// Covers owner tags, memory command layout and the starvation limit.
package cr_prefix_attach_mem_arb_pkg;

  localparam int unsigned PA_ADDR_W     = 8;
  localparam int unsigned PA_DATA_W     = 64;
  localparam int unsigned PA_STARVE_MAX = 4;
  localparam int unsigned PA_WAIT_W     = 4;

  typedef enum logic {
    PA_OWN_DP  = 1'b0,
    PA_OWN_REG = 1'b1
  } pa_owner_e;

  // Default-width view of a memory command; the arbiter builds a parameter-sized equivalent.
  typedef struct packed {
    logic                 cs;
    logic                 we;
    logic [PA_ADDR_W-1:0] addr;
    logic [PA_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic      vld;
    pa_owner_e owner;
  } rd_tag_t;

  function automatic logic [PA_WAIT_W-1:0] wait_sat_inc(input logic [PA_WAIT_W-1:0] cnt,
                                                        input logic [PA_WAIT_W-1:0] max);
    return (cnt >= max) ? max : cnt + PA_WAIT_W'(1);
  endfunction

endpackage

// File: rtl/cr_prefix_attach_rd_tag_pipe.sv
// Read-tag shift register: RD_LAT+1 stages of {valid, owner}.
// Stage 0 lines up with mem_cs, the last stage lines up with mem_rdata.
module cr_prefix_attach_rd_tag_pipe
  import cr_prefix_attach_mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    any_vld
);

  localparam int unsigned Stages = RD_LAT + 1;

  rd_tag_t stage_q [Stages];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Stages); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < int'(Stages); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[Stages-1];

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < int'(Stages); i++) begin
      any_vld = any_vld | stage_q[i].vld;
    end
  end

endmodule

// File: rtl/cr_prefix_attach_mem_arb.sv
// Arbiter for one single-port prefix memory shared by the core read port and the
// regfile indirect-access port; returns tagged read data to the right requester.
module cr_prefix_attach_mem_arb
  import cr_prefix_attach_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = PA_ADDR_W,
  parameter int unsigned DATA_W     = PA_DATA_W,
  parameter int unsigned RD_LAT     = 1,             // legal 1..4
  parameter int unsigned STARVE_MAX = PA_STARVE_MAX  // legal 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dp_req,
  input  logic [ADDR_W-1:0] dp_addr,
  output logic              dp_yield,
  output logic              dp_rvalid,
  output logic [DATA_W-1:0] dp_rdata,
  input  logic              reg_req,
  input  logic              reg_we,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic              reg_ack,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_busy
);

  typedef struct packed {
    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  localparam logic [PA_WAIT_W-1:0] WaitMax = PA_WAIT_W'(STARVE_MAX);

  logic [PA_WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                 reg_inflight_q, reg_inflight_d;
  logic                 reg_pending, reg_grant, dp_grant;
  mem_cmd_t             mem_q, mem_d;
  rd_tag_t              tag_in, tag_out;
  logic                 tag_any_vld;
  logic                 dp_hit, reg_hit;
  logic                 dp_rvalid_q, reg_ack_q;
  logic [DATA_W-1:0]    dp_rdata_q, reg_rdata_q;

  // A granted reg access is masked until its ack, including the ack cycle itself.
  assign reg_pending = reg_req & ~reg_inflight_q;
  assign reg_grant   = reg_pending & (~dp_req | (wait_cnt_q == WaitMax));
  assign dp_grant    = dp_req & ~reg_grant;
  assign dp_yield    = dp_req & reg_grant;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!reg_pending || reg_grant) begin
      wait_cnt_d = '0;
    end else if (dp_grant) begin
      wait_cnt_d = wait_sat_inc(wait_cnt_q, WaitMax);
    end
  end

  always_comb begin
    mem_d = '0;
    if (reg_grant) begin
      mem_d.cs    = 1'b1;
      mem_d.we    = reg_we;
      mem_d.addr  = reg_addr;
      mem_d.wdata = reg_we ? reg_wdata : '0;
    end else if (dp_grant) begin
      mem_d.cs   = 1'b1;
      mem_d.addr = dp_addr;
    end
  end

  assign tag_in.vld   = mem_d.cs & ~mem_d.we;
  assign tag_in.owner = reg_grant ? PA_OWN_REG : PA_OWN_DP;

  always_comb begin
    reg_inflight_d = reg_inflight_q;
    if (reg_ack_q) begin
      reg_inflight_d = 1'b0;
    end else if (reg_grant) begin
      reg_inflight_d = 1'b1;
    end
  end

  cr_prefix_attach_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .any_vld (tag_any_vld)
  );

  assign dp_hit  = tag_out.vld & (tag_out.owner == PA_OWN_DP);
  assign reg_hit = tag_out.vld & (tag_out.owner == PA_OWN_REG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q     <= '0;
      reg_inflight_q <= 1'b0;
      mem_q          <= '0;
      dp_rvalid_q    <= 1'b0;
      dp_rdata_q     <= '0;
      reg_ack_q      <= 1'b0;
      reg_rdata_q    <= '0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      reg_inflight_q <= reg_inflight_d;
      mem_q          <= mem_d;
      dp_rvalid_q    <= dp_hit;
      // Write acks coincide with mem_we; read acks come back through the tag pipe.
      reg_ack_q      <= reg_hit | (reg_grant & reg_we);
      if (dp_hit) begin
        dp_rdata_q <= mem_rdata;
      end
      if (reg_hit) begin
        reg_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_cs    = mem_q.cs;
  assign mem_we    = mem_q.we;
  assign mem_addr  = mem_q.addr;
  assign mem_wdata = mem_q.wdata;
  assign dp_rvalid = dp_rvalid_q;
  assign dp_rdata  = dp_rdata_q;
  assign reg_ack   = reg_ack_q;
  assign reg_rdata = reg_rdata_q;
  assign arb_busy  = reg_inflight_q | tag_any_vld | mem_q.cs;

  // Accepted core reads not yet answered; feeds the response-count property only.
  logic [3:0] dp_outstanding_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_outstanding_q <= '0;
    end else begin
      dp_outstanding_q <= dp_outstanding_q + {3'b000, dp_grant} - {3'b000, dp_rvalid_q};
    end
  end

  a_mem_addr_known : assert property (@(posedge clk) disable iff (!rst_n)
    mem_cs |-> !$isunknown(mem_addr));

  a_reg_ack_granted : assert property (@(posedge clk) disable iff (!rst_n)
    reg_ack |-> reg_inflight_q);

  a_dp_rvalid_owed : assert property (@(posedge clk) disable iff (!rst_n)
    dp_rvalid |-> (dp_outstanding_q != 4'd0));

  a_dp_all_answered : assert property (@(posedge clk) disable iff (!rst_n)
    (!arb_busy && !dp_rvalid) |-> (dp_outstanding_q == 4'd0));

endmodule

// File: tb/tb_cr_prefix_attach_mem_arb.sv
// Directed bench for cr_prefix_attach_mem_arb with a behavioural RD_LAT-cycle memory.
// Expected values are hand-derived from grant cycles and the preload pattern C0DE...<addr>.
module tb_cr_prefix_attach_mem_arb;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned RD_LAT     = 3;
  localparam int unsigned STARVE_MAX = 4;
  localparam int          LAT        = 5;  // grant to registered read response

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dp_req = 1'b0;
  logic [ADDR_W-1:0] dp_addr = '0;
  logic              dp_yield, dp_rvalid;
  logic [DATA_W-1:0] dp_rdata;
  logic              reg_req = 1'b0;
  logic              reg_we = 1'b0;
  logic [ADDR_W-1:0] reg_addr = '0;
  logic [DATA_W-1:0] reg_wdata = '0;
  logic              reg_ack;
  logic [DATA_W-1:0] reg_rdata;
  logic              mem_cs, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              arb_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cr_prefix_attach_mem_arb #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LAT     (RD_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dp_req    (dp_req),
    .dp_addr   (dp_addr),
    .dp_yield  (dp_yield),
    .dp_rvalid (dp_rvalid),
    .dp_rdata  (dp_rdata),
    .reg_req   (reg_req),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_ack   (reg_ack),
    .reg_rdata (reg_rdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .arb_busy  (arb_busy)
  );

  logic [205:0] all_outs;
  assign all_outs = {dp_yield, dp_rvalid, dp_rdata, reg_ack, reg_rdata,
                     mem_cs, mem_we, mem_addr, mem_wdata, arb_busy};

  // Memory: unwritten words read as C0DE_0000_0000_00<addr>.
  logic [DATA_W-1:0] wmem [256];
  bit                written [256];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (mem_cs && mem_we) begin
      wmem[mem_addr]    <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    if (mem_cs && !mem_we) begin
      rd_pipe[0] <= written[mem_addr] ? wmem[mem_addr] : {56'hC0DE_0000_0000_00, mem_addr};
    end else begin
      rd_pipe[0] <= '0;
    end
    for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Event log sampled mid-cycle.
  int          dp_cyc[$];
  logic [63:0] dp_dat[$];
  int          ack_cyc[$];
  logic [63:0] ack_dat[$];
  int          cs_cyc[$];
  logic [7:0]  cs_addr[$];
  logic        cs_we[$];
  int          yld_cyc[$];

  always @(negedge clk) begin
    if (dp_rvalid === 1'b1) begin
      dp_cyc.push_back(cyc);
      dp_dat.push_back(dp_rdata);
    end
    if (reg_ack === 1'b1) begin
      ack_cyc.push_back(cyc);
      ack_dat.push_back(reg_rdata);
    end
    if (mem_cs === 1'b1) begin
      cs_cyc.push_back(cyc);
      cs_addr.push_back(mem_addr);
      cs_we.push_back(mem_we);
    end
    if (dp_yield === 1'b1) yld_cyc.push_back(cyc);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %0h expected 0", all_outs);
    end
    next_cycle();
    rst_n = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("FAIL post_reset_idle: got %0h expected 0", all_outs);
    end
  endtask

  task automatic test_stream();
    int b_dp, b_cs, b_y, s;
    b_dp = dp_cyc.size();
    b_cs = cs_cyc.size();
    b_y  = yld_cyc.size();
    s    = 0;
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      if (i == 0) s = cyc;
      dp_req  = 1'b1;
      dp_addr = 8'(i);
    end
    next_cycle();
    dp_req = 1'b0;
    repeat (LAT + 3) next_cycle();
    checks++;
    if (cs_cyc.size() - b_cs != 16 || cs_cyc[b_cs] != s + 1 || cs_cyc[b_cs+15] != s + 16) begin
      failures++;
      $display("FAIL stream_mem_cs: got %0d accesses expected 16 in cycles %0d..%0d",
               cs_cyc.size() - b_cs, s + 1, s + 16);
    end
    checks++;
    if (yld_cyc.size() != b_y) begin
      failures++;
      $display("FAIL stream_yield: got %0d yields expected 0", yld_cyc.size() - b_y);
    end
    checks++;
    if (dp_cyc.size() - b_dp != 16) begin
      failures++;
      $display("FAIL stream_rvalid_count: got %0d expected 16", dp_cyc.size() - b_dp);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (dp_dat[b_dp+i] !== 64'hC0DE_0000_0000_0000 + 64'(i) ||
            dp_cyc[b_dp+i] != s + LAT + i) begin
          failures++;
          $display("FAIL stream_data[%0d]: got %0h at cycle %0d expected %0h at cycle %0d", i,
                   dp_dat[b_dp+i], dp_cyc[b_dp+i], 64'hC0DE_0000_0000_0000 + 64'(i),
                   s + LAT + i);
        end
      end
    end
  endtask

  task automatic reg_txn(input logic we, input logic [7:0] addr, input logic [63:0] wdata,
                         output int g, output int ack_at, output logic [63:0] rd,
                         output bit got);
    next_cycle();
    g         = cyc;
    got       = 1'b0;
    ack_at    = -1;
    rd        = '0;
    reg_req   = 1'b1;
    reg_we    = we;
    reg_addr  = addr;
    reg_wdata = wdata;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (reg_ack === 1'b1) begin
        got    = 1'b1;
        ack_at = cyc;
        rd     = reg_rdata;
        break;
      end
    end
    next_cycle();
    reg_req = 1'b0;
    reg_we  = 1'b0;
  endtask

  task automatic test_reg_wr_rd();
    int g, ack_at, b_cs;
    logic [63:0] rd;
    bit got;
    b_cs = cs_cyc.size();
    reg_txn(1'b1, 8'h05, 64'h0000_0000_DEAD_BEEF, g, ack_at, rd, got);
    checks++;
    if (!got || ack_at != g + 1) begin
      failures++;
      $display("FAIL reg_write_ack: got cycle %0d expected %0d", ack_at, g + 1);
    end
    checks++;
    if (cs_cyc.size() - b_cs != 1 || cs_cyc[b_cs] != g + 1 || cs_we[b_cs] !== 1'b1 ||
        cs_addr[b_cs] !== 8'h05) begin
      failures++;
      $display("FAIL reg_write_mem: got %0d accesses expected one write to 05 at cycle %0d",
               cs_cyc.size() - b_cs, g + 1);
    end
    repeat (2) next_cycle();
    reg_txn(1'b0, 8'h05, 64'h0, g, ack_at, rd, got);
    checks++;
    if (!got || ack_at != g + LAT) begin
      failures++;
      $display("FAIL reg_read_ack: got cycle %0d expected %0d", ack_at, g + LAT);
    end
    checks++;
    if (rd !== 64'h0000_0000_DEAD_BEEF) begin
      failures++;
      $display("FAIL reg_read_data: got %0h expected deadbeef", rd);
    end
    repeat (3) next_cycle();
  endtask

  task automatic test_starve();
    int b_dp, b_ack, b_cs, b_y, s, acc, g;
    bit reg_on;
    logic [7:0] ea;
    b_dp  = dp_cyc.size();
    b_ack = ack_cyc.size();
    b_cs  = cs_cyc.size();
    b_y   = yld_cyc.size();
    acc    = 0;
    reg_on = 1'b1;
    s      = 0;
    for (int k = 0; k < 20 && acc < 10; k++) begin
      next_cycle();
      if (k == 0) s = cyc;
      dp_req   = 1'b1;
      dp_addr  = 8'h20 + 8'(acc);
      reg_req  = reg_on;
      reg_we   = 1'b0;
      reg_addr = 8'h40;
      @(negedge clk);
      if (dp_yield !== 1'b1) acc++;
      if (reg_ack === 1'b1) reg_on = 1'b0;
    end
    next_cycle();
    dp_req  = 1'b0;
    reg_req = 1'b0;
    repeat (LAT + 3) next_cycle();
    checks++;
    if (yld_cyc.size() - b_y != 1 || yld_cyc[b_y] != s + 4) begin
      failures++;
      $display("FAIL starve_yield: got %0d yields expected one at cycle %0d",
               yld_cyc.size() - b_y, s + 4);
    end
    checks++;
    if (cs_cyc.size() - b_cs != 11) begin
      failures++;
      $display("FAIL starve_access_count: got %0d expected 11", cs_cyc.size() - b_cs);
    end else begin
      for (int k = 0; k < 11; k++) begin
        ea = (k < 4) ? 8'h20 + 8'(k) : (k == 4) ? 8'h40 : 8'h20 + 8'(k - 1);
        checks++;
        if (cs_addr[b_cs+k] !== ea || cs_we[b_cs+k] !== 1'b0 || cs_cyc[b_cs+k] != s + 1 + k)
        begin
          failures++;
          $display("FAIL starve_access[%0d]: got addr %0h at cycle %0d expected %0h at %0d", k,
                   cs_addr[b_cs+k], cs_cyc[b_cs+k], ea, s + 1 + k);
        end
      end
    end
    checks++;
    if (dp_cyc.size() - b_dp != 10) begin
      failures++;
      $display("FAIL starve_rvalid_count: got %0d expected 10", dp_cyc.size() - b_dp);
    end else begin
      for (int i = 0; i < 10; i++) begin
        g = (i < 4) ? s + i : s + i + 1;
        checks++;
        if (dp_dat[b_dp+i] !== 64'hC0DE_0000_0000_0020 + 64'(i) || dp_cyc[b_dp+i] != g + LAT)
        begin
          failures++;
          $display("FAIL starve_dp[%0d]: got %0h at cycle %0d expected %0h at %0d", i,
                   dp_dat[b_dp+i], dp_cyc[b_dp+i], 64'hC0DE_0000_0000_0020 + 64'(i), g + LAT);
        end
      end
    end
    checks++;
    if (ack_cyc.size() - b_ack != 1 || ack_cyc[b_ack] != s + 4 + LAT ||
        ack_dat[b_ack] !== 64'hC0DE_0000_0000_0040) begin
      failures++;
      $display("FAIL starve_reg_ack: got %0d acks expected one at cycle %0d data c0de..40",
               ack_cyc.size() - b_ack, s + 4 + LAT);
    end
  endtask

  task automatic test_interleave(input logic [7:0] a_dp, input logic [7:0] a_reg,
                                 input logic [63:0] exp_reg);
    int b_dp, b_ack, c0;
    b_dp  = dp_cyc.size();
    b_ack = ack_cyc.size();
    next_cycle();
    c0       = cyc;
    dp_req   = 1'b1;
    dp_addr  = a_dp;
    reg_req  = 1'b1;
    reg_we   = 1'b0;
    reg_addr = a_reg;
    next_cycle();
    dp_req = 1'b0;
    next_cycle();
    dp_req  = 1'b1;
    dp_addr = a_dp + 8'h01;
    next_cycle();
    dp_req = 1'b0;
    repeat (4) next_cycle();
    reg_req = 1'b0;
    repeat (LAT + 2) next_cycle();
    checks++;
    if (dp_cyc.size() - b_dp != 2 || dp_cyc[b_dp] != c0 + LAT || dp_cyc[b_dp+1] != c0 + 2 + LAT ||
        dp_dat[b_dp] !== {56'hC0DE_0000_0000_00, a_dp} ||
        dp_dat[b_dp+1] !== {56'hC0DE_0000_0000_00, a_dp + 8'h01}) begin
      failures++;
      $display("FAIL interleave_dp(%0h): got %0d responses expected 2 at cycles %0d,%0d",
               a_dp, dp_cyc.size() - b_dp, c0 + LAT, c0 + 2 + LAT);
    end
    checks++;
    if (ack_cyc.size() - b_ack != 1 || ack_cyc[b_ack] != c0 + 1 + LAT) begin
      failures++;
      $display("FAIL interleave_reg_ack(%0h): got %0d acks expected one at cycle %0d",
               a_reg, ack_cyc.size() - b_ack, c0 + 1 + LAT);
    end else begin
      checks++;
      if (ack_dat[b_ack] !== exp_reg) begin
        failures++;
        $display("FAIL interleave_reg_data(%0h): got %0h expected %0h", a_reg, ack_dat[b_ack],
                 exp_reg);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int b_dp, b_ack;
    b_dp  = dp_cyc.size();
    b_ack = ack_cyc.size();
    next_cycle();
    dp_req  = 1'b1;
    dp_addr = 8'h10;
    next_cycle();
    dp_addr = 8'h11;
    next_cycle();
    dp_req   = 1'b0;
    reg_req  = 1'b1;
    reg_we   = 1'b0;
    reg_addr = 8'h12;
    next_cycle();
    rst_n   = 1'b0;
    reg_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (all_outs !== '0) begin
        failures++;
        $display("FAIL reset_midflight_outputs[%0d]: got %0h expected 0", k, all_outs);
      end
      next_cycle();
    end
    rst_n = 1'b1;
    repeat (10) next_cycle();
    checks++;
    if (dp_cyc.size() != b_dp || ack_cyc.size() != b_ack) begin
      failures++;
      $display("FAIL reset_dropped_tags: got %0d rvalid %0d ack expected 0 0",
               dp_cyc.size() - b_dp, ack_cyc.size() - b_ack);
    end
    @(negedge clk);
    checks++;
    if (arb_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_arb_busy: got %b expected 0", arb_busy);
    end
  endtask

  task automatic test_back_to_back_req();
    int b_cs, b_ack, c0, g, ack_at;
    logic [63:0] rd;
    bit got;
    b_cs  = cs_cyc.size();
    b_ack = ack_cyc.size();
    next_cycle();
    c0        = cyc;
    reg_req   = 1'b1;
    reg_we    = 1'b1;
    reg_addr  = 8'h07;
    reg_wdata = 64'h1234_5678_9ABC_DEF0;
    repeat (4) next_cycle();
    reg_req = 1'b0;
    reg_we  = 1'b0;
    repeat (3) next_cycle();
    checks++;
    if (cs_cyc.size() - b_cs != 2 || cs_cyc[b_cs] != c0 + 1 || cs_cyc[b_cs+1] != c0 + 3) begin
      failures++;
      $display("FAIL held_req_accesses: got %0d expected 2 at cycles %0d,%0d",
               cs_cyc.size() - b_cs, c0 + 1, c0 + 3);
    end
    checks++;
    if (ack_cyc.size() - b_ack != 2 || ack_cyc[b_ack] != c0 + 1 || ack_cyc[b_ack+1] != c0 + 3)
    begin
      failures++;
      $display("FAIL held_req_acks: got %0d expected 2 at cycles %0d,%0d",
               ack_cyc.size() - b_ack, c0 + 1, c0 + 3);
    end
    reg_txn(1'b0, 8'h07, 64'h0, g, ack_at, rd, got);
    checks++;
    if (!got || ack_at != g + LAT || rd !== 64'h1234_5678_9ABC_DEF0) begin
      failures++;
      $display("FAIL held_req_readback: got %0h at cycle %0d expected 123456789abcdef0 at %0d",
               rd, ack_at, g + LAT);
    end
    repeat (3) next_cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_reg_wr_rd();
    test_starve();
    test_interleave(8'h60, 8'h50, 64'hC0DE_0000_0000_0050);
    test_interleave(8'h70, 8'h05, 64'h0000_0000_DEAD_BEEF);
    test_reset_midflight();
    test_back_to_back_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cr_prefix_attach_mem_arb.md
Name: cr_prefix_attach_mem_arb

Overview:
Arbiter and sequencer for one single-port prefix memory (PFD or PHD) inside the prefix-attach block. It shares the memory between the datapath core read port and the register-file indirect-access port. It generates the core's yield indication and returns tagged read data to the correct requester after a fixed read latency. The block is instantiated once per memory, between the core/regfile and the RAM wrapper.

Parameters:
ADDR_W  8  memory address width (entries = 2**ADDR_W)
DATA_W  64  memory word width
RD_LAT  1  memory read latency in cycles, legal range 1..4
STARVE_MAX  4  max consecutive cycles a pending reg request may lose to the core, legal range 1..15

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
dp_req  in  1  core read request, one access per cycle
dp_addr  in  ADDR_W  core read address
dp_yield  out  1  core request not accepted this cycle; core holds dp_req/dp_addr
dp_rvalid  out  1  core read data valid
dp_rdata  out  DATA_W  core read data
reg_req  in  1  regfile access request, level, held until reg_ack
reg_we  in  1  1=write, 0=read
reg_addr  in  ADDR_W  regfile address
reg_wdata  in  DATA_W  regfile write data
reg_ack  out  1  single-cycle completion pulse (write: grant+1; read: data valid)
reg_rdata  out  DATA_W  regfile read data, valid with reg_ack on reads
mem_cs  out  1  memory chip select
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, RD_LAT cycles after mem_cs & !mem_we
arb_busy  out  1  any access in flight or pending

Behaviour:
- Reset: all outputs 0. wait_cnt = 0. Read-tag pipeline cleared.
- Per-cycle arbitration is combinational, with registered memory outputs (mem_* driven from flops, 1 cycle after grant).
- Grant rules:
  - Core wins by default.
  - Reg wins if dp_req=0, or if wait_cnt == STARVE_MAX.
- dp_yield = dp_req & reg_grant, combinational in the same cycle.
- wait_cnt:
  - Increments (saturating at STARVE_MAX) each cycle reg_req=1 and the core is granted.
  - Clears to 0 on reg grant or when reg_req=0.
- Reg request lifecycle: reg_req is masked from re-arbitration after grant (reg_inflight flag) until reg_ack. A reg_req still high in the cycle of reg_ack is not re-granted until the following cycle.
- Read tag pipeline: shift register of RD_LAT+1 stages carrying {valid, owner}. The stage aligned to mem_rdata steers the data:
  - owner=core: dp_rvalid=1, dp_rdata=mem_rdata.
  - owner=reg: reg_ack=1, reg_rdata=mem_rdata.
  - dp_rdata and reg_rdata are registered, so data appears RD_LAT+2 cycles after grant.
- Reg write: mem_we=1 in the cycle after grant; reg_ack pulses in that same cycle.
- Throughput: one memory access per cycle, no bubbles between back-to-back core reads.
- Simultaneous dp_req and reg_req with wait_cnt < STARVE_MAX: core wins and wait_cnt increments.
- Reset asserted mid-operation: in-flight tags are dropped, with no rvalid/ack afterwards. Requesters reissue.
- arb_busy = reg_inflight | any tag valid | mem_cs.
- Assertions:
  - No mem_cs with X address.
  - reg_ack never without prior grant.
  - dp_rvalid count equals accepted dp_req count.

Decomposition:
- cr_prefix_attachPKG gets:
  - the owner enum (PA_OWN_DP, PA_OWN_REG)
  - a packed mem_req_t {cs, we, addr, wdata}
  - rd_tag_t {vld, owner}
  - the default STARVE_MAX constant
- One sub-module is natural: cr_prefix_attach_rd_tag_pipe, the parameterised tag shift register.

Test Plan:
- Core streams reads to addr 0..15 with reg idle -> mem_cs continuous 16 cycles; dp_rvalid 16 consecutive cycles; data matches preloaded memory; dp_yield never asserted.
- Core idle, reg write 0xDEAD_BEEF to addr 5 then reg read addr 5 -> write reg_ack at grant+1; read reg_ack at grant+RD_LAT+2 with reg_rdata=0xDEAD_BEEF.
- Core reads continuously while reg_req asserted, STARVE_MAX=4 -> reg granted on 5th cycle; dp_yield=1 exactly that cycle; core address held and accepted the next cycle; no lost or duplicate dp_rvalid.
- RD_LAT=3, core and reg reads interleaved -> each response routed to its correct owner in issue order.
- rst_n pulsed low with 2 core reads and 1 reg read in flight -> all outputs 0 during reset; no dp_rvalid or reg_ack after release; arb_busy=0.
- reg_req held high across reg_ack -> exactly one memory access per request; second access granted no earlier than cycle after ack.
